axi_full_burst_slave: RTL and testbench

//  AXI4-full memory-mapped responder (slave): word-addressed register RAM with FIXED/INCR/WRAP bursts.

---
 rtl/axi_full_burst_slave_if.sv | 65 ++++++
 rtl/axi_full_burst_slave.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_axi_full_burst_slave.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_full_burst_slave_if.sv
// AXI4-full bus bundle for axi_full_burst_slave.
// The master modport drives requests and the slave modport drives responses.
interface axi_full_burst_slave_if #(
    parameter int ID_WIDTH   = 1,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_full_burst_slave.sv
// AXI4-full word RAM responder with independent write/read burst FSMs (FIXED/INCR/WRAP).
// Define AXI_SLV_WRAP_EN to accept WRAP bursts of 2/4/8/16 beats; otherwise WRAP gets SLVERR.
module axi_full_burst_slave #(
    parameter int C_S00_AXI_ID_WIDTH   = 1,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 8
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_aresetn,
    axi_full_burst_slave_if.slave s00_axi
);
    localparam int IW    = C_S00_AXI_ID_WIDTH;
    localparam int DW    = C_S00_AXI_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int WA    = C_S00_AXI_ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << WA;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_SLV_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len);
        logic bad;
        logic len_ok;
        len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        case (burst)
            BURST_FIXED: bad = 1'b0;
            BURST_INCR:  bad = 1'b0;
            BURST_WRAP:  bad = !(WRAP_EN && len_ok);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

    // WRAP keeps the upper address bits and lets the low len bits roll over.
    function automatic logic [WA-1:0] next_addr(input logic [WA-1:0] a, input logic [1:0] burst,
                                                input logic [7:0] len);
        logic [WA-1:0] inc;
        logic [WA-1:0] msk;
        logic [WA-1:0] n;
        inc = a + WA'(1);
        msk = WA'(len);
        case (burst)
            BURST_INCR: n = inc;
            BURST_WRAP: n = (a & ~msk) | (inc & msk);
            default:    n = a;
        endcase
        return n;
    endfunction

    logic [DW-1:0] mem_q [DEPTH];

    w_state_e      w_state_q, w_state_d;
    logic          awready_q, awready_d;
    logic          wready_q,  wready_d;
    logic          bvalid_q,  bvalid_d;
    logic [IW-1:0] bid_q,     bid_d;
    logic [1:0]    bresp_q,   bresp_d;
    logic [WA-1:0] waddr_q,   waddr_d;
    logic [7:0]    wlen_q,    wlen_d;
    logic [7:0]    wcnt_q,    wcnt_d;
    logic [1:0]    wburst_q,  wburst_d;
    logic          werr_q,    werr_d;

    r_state_e      r_state_q, r_state_d;
    logic          arready_q, arready_d;
    logic          rvalid_q,  rvalid_d;
    logic          rlast_q,   rlast_d;
    logic [IW-1:0] rid_q,     rid_d;
    logic [1:0]    rresp_q,   rresp_d;
    logic [DW-1:0] rdata_q,   rdata_d;
    logic [WA-1:0] raddr_q,   raddr_d;
    logic [7:0]    rlen_q,    rlen_d;
    logic [7:0]    rcnt_q,    rcnt_d;
    logic [1:0]    rburst_q,  rburst_d;
    logic          rerr_q,    rerr_d;

    logic          w_beat_s;
    logic          w_last_s;
    logic          mem_we_s;
    logic          aw_err_s;
    logic          ar_err_s;
    logic [WA-1:0] aw_word_s;
    logic [WA-1:0] ar_word_s;
    logic [WA-1:0] w_next_s;
    logic [WA-1:0] r_next_s;
    logic          unused_s;

    assign aw_word_s = s00_axi.awaddr[WA+1:2];
    assign ar_word_s = s00_axi.araddr[WA+1:2];
    assign aw_err_s  = burst_illegal(s00_axi.awburst, s00_axi.awlen);
    assign ar_err_s  = burst_illegal(s00_axi.arburst, s00_axi.arlen);
    assign w_next_s  = next_addr(waddr_q, wburst_q, wlen_q);
    assign r_next_s  = next_addr(raddr_q, rburst_q, rlen_q);
    assign w_beat_s  = (w_state_q == W_DATA) && wready_q && s00_axi.wvalid;
    assign w_last_s  = (wcnt_q == wlen_q);
    assign mem_we_s  = w_beat_s && !werr_q;
    assign unused_s  = ^{s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    assign s00_axi.awready = awready_q;
    assign s00_axi.wready  = wready_q;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bid     = bid_q;
    assign s00_axi.bresp   = bresp_q;
    assign s00_axi.arready = arready_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rlast   = rlast_q;
    assign s00_axi.rid     = rid_q;
    assign s00_axi.rresp   = rresp_q;
    assign s00_axi.rdata   = rdata_q;

    // Write channel next state: address accept, beat absorb, response hold.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = 1'b0;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        wburst_d  = wburst_q;
        werr_d    = werr_q;
        case (w_state_q)
            W_IDLE: begin
                if (awready_q && s00_axi.awvalid) begin
                    bid_d     = s00_axi.awid;
                    waddr_d   = aw_word_s;
                    wlen_d    = s00_axi.awlen;
                    wburst_d  = s00_axi.awburst;
                    wcnt_d    = 8'd0;
                    werr_d    = aw_err_s;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end else begin
                    awready_d = s00_axi.awvalid && !awready_q;
                end
            end
            W_DATA: begin
                if (w_beat_s) begin
                    if (s00_axi.wlast || w_last_s) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (s00_axi.wlast && w_last_s && !werr_q) ? RESP_OKAY : RESP_SLVERR;
                        w_state_d = W_RESP;
                    end else begin
                        waddr_d = w_next_s;
                        wcnt_d  = wcnt_q + 8'd1;
                    end
                end else begin
                    wready_d = 1'b1;
                end
            end
            W_RESP: begin
                if (s00_axi.bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end else begin
                    bvalid_d  = 1'b1;
                end
            end
            default: begin
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Write channel state and registered outputs.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= {IW{1'b0}};
            bresp_q   <= 2'b00;
            waddr_q   <= {WA{1'b0}};
            wlen_q    <= 8'd0;
            wcnt_q    <= 8'd0;
            wburst_q  <= 2'b00;
            werr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wburst_q  <= wburst_d;
            werr_q    <= werr_d;
        end
    end

    // Byte-lane write port; the array is deliberately left out of reset.
    always_ff @(posedge s00_axi_aclk) begin
        if (mem_we_s) begin
            for (int b = 0; b < SW; b++) begin
                if (s00_axi.wstrb[b]) begin
                    mem_q[waddr_q][b*8 +: 8] <= s00_axi.wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read channel next state; data is fetched one beat ahead so rdata is registered.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rburst_d  = rburst_q;
        rerr_d    = rerr_q;
        case (r_state_q)
            R_IDLE: begin
                if (arready_q && s00_axi.arvalid) begin
                    rid_d     = s00_axi.arid;
                    raddr_d   = ar_word_s;
                    rlen_d    = s00_axi.arlen;
                    rburst_d  = s00_axi.arburst;
                    rcnt_d    = 8'd0;
                    rerr_d    = ar_err_s;
                    rvalid_d  = 1'b1;
                    rlast_d   = (s00_axi.arlen == 8'd0);
                    rresp_d   = ar_err_s ? RESP_SLVERR : RESP_OKAY;
                    rdata_d   = ar_err_s ? {DW{1'b0}} : mem_q[ar_word_s];
                    r_state_d = R_DATA;
                end else begin
                    arready_d = s00_axi.arvalid && !arready_q;
                end
            end
            R_DATA: begin
                if (rvalid_q && s00_axi.rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        raddr_d = r_next_s;
                        rcnt_d  = rcnt_q + 8'd1;
                        rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                        rdata_d = rerr_q ? {DW{1'b0}} : mem_q[r_next_s];
                    end
                end else begin
                    rvalid_d = rvalid_q;
                end
            end
            default: begin
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Read channel state and registered outputs.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= {IW{1'b0}};
            rresp_q   <= 2'b00;
            rdata_q   <= {DW{1'b0}};
            raddr_q   <= {WA{1'b0}};
            rlen_q    <= 8'd0;
            rcnt_q    <= 8'd0;
            rburst_q  <= 2'b00;
            rerr_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rburst_q  <= rburst_d;
            rerr_q    <= rerr_d;
        end
    end
endmodule

// File: tb/tb_axi_full_burst_slave.sv
// Directed bench for axi_full_burst_slave: bursts, strobes, wrap, protocol errors, backpressure, reset.
// Expectations for WRAP bursts follow AXI_SLV_WRAP_EN.
module tb_axi_full_burst_slave;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   n_tmo;

    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];
    logic [1:0]  rrsp [16];
    logic        rlst [16];
    logic        first_rvalid;
    logic        after_rvalid;
    logic        last_bid;
    logic        last_rid;

    axi_full_burst_slave_if #(.ID_WIDTH(1), .DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

    axi_full_burst_slave dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi         (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] strb, input int last_at, input bit do_resp,
                             output logic [1:0] resp);
        int g;
        int nb;
        resp         = 2'b11;
        bus.awid     = 1'b1;
        bus.awaddr   = addr;
        bus.awlen    = len;
        bus.awburst  = burst;
        bus.awvalid  = 1'b1;
        g = 0;
        while (!bus.awready && g < 50) begin step(); g++; end
        if (g >= 50) n_tmo++;
        step();
        bus.awvalid = 1'b0;
        nb = (last_at <= int'(len)) ? last_at + 1 : int'(len) + 1;
        for (int i = 0; i < nb; i++) begin
            bus.wdata  = wbuf[i];
            bus.wstrb  = strb;
            bus.wlast  = (i == last_at);
            bus.wvalid = 1'b1;
            g = 0;
            while (!bus.wready && g < 50) begin step(); g++; end
            if (g >= 50) n_tmo++;
            step();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        if (do_resp) begin
            bus.bready = 1'b1;
            g = 0;
            while (!bus.bvalid && g < 50) begin step(); g++; end
            if (g >= 50) n_tmo++;
            resp     = bus.bresp;
            last_bid = bus.bid;
            step();
            bus.bready = 1'b0;
        end
    endtask

    task automatic ar_issue(input logic [7:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int g;
        bus.arid    = 1'b1;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        g = 0;
        while (!bus.arready && g < 50) begin step(); g++; end
        if (g >= 50) n_tmo++;
        step();
        bus.arvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input bit toggle);
        int g;
        int n;
        ar_issue(addr, len, burst);
        first_rvalid = bus.rvalid;
        n = 0;
        g = 0;
        while (n <= int'(len) && g < 200) begin
            bus.rready = toggle ? ((g % 2) == 0) : 1'b1;
            if (bus.rvalid && bus.rready) begin
                rbuf[n]  = bus.rdata;
                rrsp[n]  = bus.rresp;
                rlst[n]  = bus.rlast;
                last_rid = bus.rid;
                n++;
            end
            step();
            g++;
        end
        if (g >= 200) n_tmo++;
        bus.rready   = 1'b0;
        after_rvalid = bus.rvalid;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [3:0]  lastv;
        logic [1:0]  rsp_or;
        logic [31:0] exp4 [4];
        logic        held;
        logic        aw_seen;
        n_checks = 0; n_fail = 0; n_tmo = 0;
        clk = 1'b0; rst_n = 1'b0;
        bus.awid = 1'b0; bus.awaddr = 8'd0; bus.awlen = 8'd0; bus.awburst = 2'b00; bus.awvalid = 1'b0;
        bus.wdata = 32'd0; bus.wstrb = 4'd0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = 1'b0; bus.araddr = 8'd0; bus.arlen = 8'd0; bus.arburst = 2'b00; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        last_bid = 1'b0; last_rid = 1'b0;
        repeat (3) step();
        check_eq("reset_ctrl", 32'({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid,
                                    bus.rlast, bus.bresp, bus.rresp, bus.bid, bus.rid}), 32'd0);
        check_eq("reset_rdata", bus.rdata, 32'd0);
        rst_n = 1'b1;
        step();

        // T1 INCR write then read of four words
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h0badbeaf + (32'h1000_0000 * i);
        axi_write(8'd0, 8'd3, 2'b01, 4'hF, 3, 1'b1, resp);
        check_eq("t1_bresp", 32'(resp), 32'd0);
        check_eq("t1_bid", 32'(last_bid), 32'd1);
        axi_read(8'd0, 8'd3, 2'b01, 1'b0);
        check_eq("t1_rvalid_latency", 32'(first_rvalid), 32'd1);
        for (int i = 0; i < 4; i++) check_eq($sformatf("t1_rdata%0d", i), rbuf[i], 32'h0badbeaf + (32'h1000_0000 * i));
        for (int i = 0; i < 4; i++) lastv[i] = rlst[i];
        rsp_or = rrsp[0] | rrsp[1] | rrsp[2] | rrsp[3];
        check_eq("t1_rlast", 32'(lastv), 32'h8);
        check_eq("t1_rresp", 32'(rsp_or), 32'd0);
        check_eq("t1_rid", 32'(last_rid), 32'd1);
        check_eq("t1_rvalid_end", 32'(after_rvalid), 32'd0);

        // T2 partial strobe over all-ones
        wbuf[0] = 32'hFFFF_FFFF;
        axi_write(8'd20, 8'd0, 2'b01, 4'hF, 0, 1'b1, resp);
        wbuf[0] = 32'h1122_3344;
        axi_write(8'd20, 8'd0, 2'b01, 4'b0101, 0, 1'b1, resp);
        check_eq("t2_bresp", 32'(resp), 32'd0);
        axi_read(8'd20, 8'd0, 2'b01, 1'b0);
        check_eq("t2_rdata", rbuf[0], 32'hFF22_FF44);
        check_eq("t2_rlast", 32'(rlst[0]), 32'd1);

        // T3 INCR wraps from word 63 to word 0
        wbuf[0] = 32'hA000_0000; wbuf[1] = 32'hA000_0001; wbuf[2] = 32'hA000_0002;
        axi_write(8'd248, 8'd2, 2'b01, 4'hF, 2, 1'b1, resp);
        check_eq("t3_bresp", 32'(resp), 32'd0);
        axi_read(8'd248, 8'd2, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) check_eq($sformatf("t3_rdata%0d", i), rbuf[i], 32'hA000_0000 + i);
        axi_read(8'd0, 8'd0, 2'b01, 1'b0);
        check_eq("t3_word0", rbuf[0], 32'hA000_0002);

        // T4 WRAP over words 4..7
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hD0D0_0004 + i;
        axi_write(8'd16, 8'd3, 2'b01, 4'hF, 3, 1'b1, resp);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0C0_0000 + i;
        axi_write(8'd24, 8'd3, 2'b10, 4'hF, 3, 1'b1, resp);
`ifdef AXI_SLV_WRAP_EN
        check_eq("t4_bresp", 32'(resp), 32'd0);
        exp4[0] = 32'hC0C0_0002; exp4[1] = 32'hC0C0_0003; exp4[2] = 32'hC0C0_0000; exp4[3] = 32'hC0C0_0001;
`else
        check_eq("t4_bresp", 32'(resp), 32'd2);
        for (int i = 0; i < 4; i++) exp4[i] = 32'hD0D0_0004 + i;
`endif
        axi_read(8'd16, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) check_eq($sformatf("t4_ram%0d", i + 4), rbuf[i], exp4[i]);
        axi_read(8'd24, 8'd3, 2'b10, 1'b0);
`ifdef AXI_SLV_WRAP_EN
        check_eq("t4_wrap_rdata1", rbuf[1], 32'hC0C0_0001);
        check_eq("t4_wrap_rdata3", rbuf[3], 32'hC0C0_0003);
        check_eq("t4_wrap_rresp", 32'(rrsp[3]), 32'd0);
`else
        check_eq("t4_wrap_rdata1", rbuf[1], 32'd0);
        check_eq("t4_wrap_rdata3", rbuf[3], 32'd0);
        check_eq("t4_wrap_rresp", 32'(rrsp[3]), 32'd2);
`endif
        check_eq("t4_wrap_rlast", 32'(rlst[3]), 32'd1);
        axi_write(8'd160, 8'd2, 2'b10, 4'hF, 2, 1'b1, resp);
        check_eq("t4_wrap_badlen", 32'(resp), 32'd2);
        axi_read(8'd4, 8'd1, 2'b11, 1'b0);
        check_eq("rsv_rdata", rbuf[1], 32'd0);
        check_eq("rsv_rresp", 32'({rrsp[0], rrsp[1]}), 32'hA);

        // FIXED write keeps hitting one word
        wbuf[0] = 32'hE0; wbuf[1] = 32'hE1; wbuf[2] = 32'hE2;
        axi_write(8'd40, 8'd2, 2'b00, 4'hF, 2, 1'b1, resp);
        check_eq("fixed_bresp", 32'(resp), 32'd0);
        axi_read(8'd40, 8'd2, 2'b00, 1'b0);
        check_eq("fixed_rdata", rbuf[2], 32'hE2);

        // T5 early wlast, stalled response, blocked next address
        wbuf[0] = 32'h50; wbuf[1] = 32'h51;
        axi_write(8'd80, 8'd3, 2'b01, 4'hF, 1, 1'b0, resp);
        check_eq("t5_early_bresp", 32'(bus.bresp), 32'd2);
        bus.awid = 1'b1; bus.awaddr = 8'd84; bus.awlen = 8'd0; bus.awburst = 2'b01; bus.awvalid = 1'b1;
        held = 1'b1; aw_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            held    = held & bus.bvalid;
            aw_seen = aw_seen | bus.awready;
        end
        check_eq("t5_bvalid_held", 32'(held), 32'd1);
        check_eq("t5_awready_blocked", 32'(aw_seen), 32'd0);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check_eq("t5_bvalid_clear", 32'(bus.bvalid), 32'd0);
        wbuf[0] = 32'h60;
        axi_write(8'd84, 8'd0, 2'b01, 4'hF, 0, 1'b1, resp);
        check_eq("t5_next_bresp", 32'(resp), 32'd0);
        axi_read(8'd80, 8'd1, 2'b01, 1'b0);
        check_eq("t5_partial0", rbuf[0], 32'h50);
        check_eq("t5_partial1", rbuf[1], 32'h60);
        wbuf[0] = 32'h70; wbuf[1] = 32'h71;
        axi_write(8'd120, 8'd1, 2'b01, 4'hF, 9, 1'b1, resp);
        check_eq("t5_missing_wlast", 32'(resp), 32'd2);

        // T6 rready toggling, then reset during a read
        axi_read(8'd4, 8'd2, 2'b01, 1'b1);
        for (int i = 0; i < 3; i++) check_eq($sformatf("t6_bp_rdata%0d", i), rbuf[i], 32'h1badbeaf + (32'h1000_0000 * i));
        check_eq("t6_bp_rlast", 32'({rlst[0], rlst[1], rlst[2]}), 32'd1);
        ar_issue(8'd4, 8'd7, 2'b01);
        bus.rready = 1'b1;
        step();
        check_eq("t6_midread_rdata", bus.rdata, 32'h2badbeaf);
        rst_n = 1'b0;
        bus.rready = 1'b0;
        step();
        check_eq("t6_reset_rvalid", 32'({bus.rvalid, bus.rlast}), 32'd0);
        rst_n = 1'b1;
        step();
        axi_read(8'd4, 8'd0, 2'b01, 1'b0);
        check_eq("t6_after_reset", rbuf[0], 32'h1badbeaf);
        check_eq("t6_after_rlast", 32'(rlst[0]), 32'd1);

        check_eq("no_timeouts", 32'(n_tmo), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
